// File: rtl/action_sequencer_if.sv
// Command port of the action sequencer: {target, func} commands under a valid/ready handshake.
// The master side issues commands and the slave side (the sequencer) accepts them.
interface action_sequencer_if #(
    parameter int TGT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [TGT_W-1:0] cmd_target;
    logic [1:0]       cmd_func;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_func,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_func,
        output cmd_ready
    );
endinterface

// File: rtl/action_sequencer.sv
// Queued action sequencer: buffers {target, func} commands and runs each one as move -> act -> gap.
// ACTION_TIMEOUT_EN enables a MOVE_TIMEOUT abort of the move phase; without it MOVE waits forever.
module action_sequencer #(
    parameter int TGT_W        = 8,
    parameter int DEPTH        = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int MOVE_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    action_sequencer_if.slave        cmd,
    input  logic                     move_ready,
    input  logic                     flush,
    output logic [TGT_W-1:0]         target_machine,
    output logic [4:0]               control_data,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int ENT_W  = TGT_W + 2;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES);

    localparam logic [1:0] FUNC_GET      = 2'd0;
    localparam logic [1:0] FUNC_PUT      = 2'd1;
    localparam logic [1:0] FUNC_INTERACT = 2'd2;
    localparam logic [1:0] FUNC_THROW    = 2'd3;

    localparam logic [4:0] CTRL_MOVE     = 5'b10000;
    localparam logic [4:0] CTRL_THROW    = 5'b01000;
    localparam logic [4:0] CTRL_INTERACT = 5'b00100;
    localparam logic [4:0] CTRL_PUT      = 5'b00010;
    localparam logic [4:0] CTRL_GET      = 5'b00001;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("action_sequencer: DEPTH must be a power of 2 and at least 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("action_sequencer: HOLD_CYCLES must be at least 1");
    end
    if (MOVE_TIMEOUT < 1) begin : g_bad_timeout
        $error("action_sequencer: MOVE_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        ACT,
        GAP
    } state_t;

    function automatic logic [4:0] func_to_ctrl(input logic [1:0] func);
        logic [4:0] ctrl;
        case (func)
            FUNC_GET:      ctrl = CTRL_GET;
            FUNC_PUT:      ctrl = CTRL_PUT;
            FUNC_INTERACT: ctrl = CTRL_INTERACT;
            default:       ctrl = CTRL_THROW;
        endcase
        return ctrl;
    endfunction

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ENT_W-1:0]  head;
    logic [TGT_W-1:0]  head_tgt;
    logic [1:0]        head_func;
    logic              push;
    logic              pop;

    state_t            state_q;
    state_t            state_d;
    logic [4:0]        ctrl_d;
    logic [TGT_W-1:0]  tgt_d;
    logic [1:0]        func_q;
    logic [1:0]        func_d;
    logic [HCNT_W-1:0] hold_q;
    logic [HCNT_W-1:0] hold_d;
    logic              tmo_d;

    assign cmd.cmd_ready = (fifo_count != FULL_CNT);
    assign push          = cmd.cmd_valid && cmd.cmd_ready && !flush;
    assign head          = mem[rd_ptr];
    assign head_tgt      = head[TGT_W-1:0];
    assign head_func     = head[ENT_W-1:TGT_W];

    assign busy = (state_q != IDLE);
    assign done = (state_q == GAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // Queue storage carries no reset; only the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd.cmd_func, cmd.cmd_target};
        end
    end

`ifdef ACTION_TIMEOUT_EN
    localparam int MCNT_W = $clog2(MOVE_TIMEOUT + 1);
    localparam logic [MCNT_W-1:0] MOVE_LAST = MCNT_W'(MOVE_TIMEOUT);

    logic [MCNT_W-1:0] move_cnt_q;
    logic              timeout_q;

    // Holds the number of cycles spent in MOVE including the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_cnt_q <= MCNT_W'(1);
        end else if (state_q != MOVE) begin
            move_cnt_q <= MCNT_W'(1);
        end else begin
            move_cnt_q <= move_cnt_q + MCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            control_data   <= '0;
            target_machine <= '0;
            func_q         <= FUNC_GET;
            hold_q         <= '0;
        end else begin
            state_q        <= state_d;
            control_data   <= ctrl_d;
            target_machine <= tgt_d;
            func_q         <= func_d;
            hold_q         <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = control_data;
        tgt_d   = target_machine;
        func_d  = func_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        tmo_d   = 1'b0;

        if (flush) begin
            state_d = IDLE;
            ctrl_d  = '0;
            tgt_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_count != '0) begin
                        pop    = 1'b1;
                        tgt_d  = head_tgt;
                        func_d = head_func;
                        hold_d = HCNT_W'(1);
                        // A throw needs no approach move, it acts from where the arm is.
                        if (head_func == FUNC_THROW) begin
                            state_d = ACT;
                            ctrl_d  = CTRL_THROW;
                        end else begin
                            state_d = MOVE;
                            ctrl_d  = CTRL_MOVE;
                        end
                    end
                end
                MOVE: begin
                    if (move_ready) begin
                        state_d = ACT;
                        ctrl_d  = func_to_ctrl(func_q);
                        hold_d  = HCNT_W'(1);
                    end
`ifdef ACTION_TIMEOUT_EN
                    else if (move_cnt_q == MOVE_LAST) begin
                        state_d = IDLE;
                        ctrl_d  = '0;
                        tmo_d   = 1'b1;
                    end
`endif
                end
                ACT: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = GAP;
                        ctrl_d  = '0;
                    end else begin
                        hold_d = hold_q + HCNT_W'(1);
                    end
                end
                GAP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    ctrl_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_sequencer.sv
// Directed bench for action_sequencer: reset, single commands, queue fill, flush, move timeout, async reset.
// Builds with or without ACTION_TIMEOUT_EN; the expected behaviour of the move phase follows the macro.
module tb_action_sequencer;

    localparam int TGT_W = 8;

    localparam logic [1:0] F_GET      = 2'd0;
    localparam logic [1:0] F_PUT      = 2'd1;
    localparam logic [1:0] F_INTERACT = 2'd2;
    localparam logic [1:0] F_THROW    = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             move_ready;
    logic             flush;
    logic [TGT_W-1:0] target_machine;
    logic [4:0]       control_data;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [2:0]       fifo_count;

    int checks   = 0;
    int failures = 0;

    action_sequencer_if #(.TGT_W(TGT_W)) cif ();

    action_sequencer #(
        .TGT_W       (TGT_W),
        .DEPTH       (4),
        .HOLD_CYCLES (2),
        .MOVE_TIMEOUT(10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (cif),
        .move_ready    (move_ready),
        .flush         (flush),
        .target_machine(target_machine),
        .control_data  (control_data),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [TGT_W-1:0] tgt, input logic [1:0] func);
        cif.cmd_valid  = v;
        cif.cmd_target = tgt;
        cif.cmd_func   = func;
    endtask

    // Entered on the first cycle after the pop; move_ready must already be high.
    task automatic expect_exec(input logic [TGT_W-1:0] tgt, input logic [4:0] act,
                               input bit has_move, input int cnt);
        chk("exec_count", 32'(fifo_count), 32'(cnt));
        chk("exec_busy", 32'(busy), 32'd1);
        if (has_move) begin
            chk("exec_move_ctrl", 32'(control_data), 32'h10);
            tick();
        end
        chk("exec_act1_ctrl", 32'(control_data), 32'(act));
        chk("exec_target", 32'(target_machine), 32'(tgt));
        tick();
        chk("exec_act2_ctrl", 32'(control_data), 32'(act));
        chk("exec_act2_done", 32'(done), 32'd0);
        tick();
        chk("exec_gap_ctrl", 32'(control_data), 32'h00);
        chk("exec_gap_done", 32'(done), 32'd1);
        tick();
        chk("exec_idle_done", 32'(done), 32'd0);
        chk("exec_idle_busy", 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        int bad_cycles;
        rst_n      = 1'b0;
        move_ready = 1'b0;
        flush      = 1'b0;
        drive(1'b0, 8'h00, F_GET);
        tick();
        tick();

        chk("rst_ctrl", 32'(control_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_target", 32'(target_machine), 32'h00);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(cif.cmd_ready), 32'd1);

        // PUT to 0x12, move_ready after three MOVE cycles
        drive(1'b1, 8'h12, F_PUT);
        tick();
        drive(1'b0, 8'h00, F_GET);
        chk("put_queued", 32'(fifo_count), 32'd1);
        chk("put_not_busy", 32'(busy), 32'd0);
        tick();
        chk("put_move0", 32'(control_data), 32'h10);
        chk("put_target", 32'(target_machine), 32'h12);
        chk("put_popped", 32'(fifo_count), 32'd0);
        tick();
        chk("put_move1", 32'(control_data), 32'h10);
        tick();
        chk("put_move2", 32'(control_data), 32'h10);
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        chk("put_act0", 32'(control_data), 32'h02);
        tick();
        chk("put_act1", 32'(control_data), 32'h02);
        chk("put_act1_done", 32'(done), 32'd0);
        tick();
        chk("put_gap_ctrl", 32'(control_data), 32'h00);
        chk("put_gap_done", 32'(done), 32'd1);
        chk("put_gap_target", 32'(target_machine), 32'h12);
        tick();
        chk("put_idle_done", 32'(done), 32'd0);
        chk("put_idle_busy", 32'(busy), 32'd0);
        chk("put_idle_target", 32'(target_machine), 32'h12);

        // THROW to 0x05 skips the move
        drive(1'b1, 8'h05, F_THROW);
        tick();
        drive(1'b0, 8'h00, F_GET);
        tick();
        chk("throw_act0", 32'(control_data), 32'h08);
        chk("throw_target", 32'(target_machine), 32'h05);
        tick();
        chk("throw_act1", 32'(control_data), 32'h08);
        tick();
        chk("throw_gap_ctrl", 32'(control_data), 32'h00);
        chk("throw_gap_done", 32'(done), 32'd1);
        tick();
        chk("throw_idle_busy", 32'(busy), 32'd0);

        // Five back-to-back pushes while the first command waits in MOVE
        drive(1'b1, 8'h21, F_GET);
        tick();
        chk("fill_count1", 32'(fifo_count), 32'd1);
        drive(1'b1, 8'h22, F_PUT);
        tick();
        chk("fill_push_pop", 32'(fifo_count), 32'd1);
        chk("fill_first_move", 32'(control_data), 32'h10);
        drive(1'b1, 8'h23, F_INTERACT);
        tick();
        drive(1'b1, 8'h24, F_THROW);
        tick();
        drive(1'b1, 8'h25, F_GET);
        tick();
        chk("fill_count4", 32'(fifo_count), 32'd4);
        chk("fill_not_ready", 32'(cif.cmd_ready), 32'd0);
        drive(1'b1, 8'h26, F_PUT);
        tick();
        chk("fill_full_no_push", 32'(fifo_count), 32'd4);
        drive(1'b0, 8'h00, F_GET);
        move_ready = 1'b1;
        expect_exec(8'h21, 5'b00001, 1'b1, 4);
        expect_exec(8'h22, 5'b00010, 1'b1, 3);
        expect_exec(8'h23, 5'b00100, 1'b1, 2);
        expect_exec(8'h24, 5'b01000, 1'b0, 1);
        expect_exec(8'h25, 5'b00001, 1'b1, 0);
        move_ready = 1'b0;
        chk("fill_drained_busy", 32'(busy), 32'd0);

        // flush during MOVE with two queued; a push on the same edge is dropped
        drive(1'b1, 8'h31, F_GET);
        tick();
        drive(1'b1, 8'h32, F_PUT);
        tick();
        drive(1'b1, 8'h33, F_GET);
        tick();
        chk("flush_pre_count", 32'(fifo_count), 32'd2);
        chk("flush_pre_busy", 32'(busy), 32'd1);
        drive(1'b1, 8'h34, F_PUT);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, F_GET);
        chk("flush_ctrl", 32'(control_data), 32'h00);
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_target", 32'(target_machine), 32'h00);
        chk("flush_ready", 32'(cif.cmd_ready), 32'd1);
        tick();
        chk("flush_after_busy", 32'(busy), 32'd0);
        chk("flush_after_done", 32'(done), 32'd0);

        // Stalled move: aborted by timeout when enabled, waits indefinitely otherwise
        drive(1'b1, 8'h41, F_GET);
        tick();
        drive(1'b1, 8'h42, F_THROW);
        tick();
        drive(1'b0, 8'h00, F_GET);
        chk("stall_move0", 32'(control_data), 32'h10);
`ifdef ACTION_TIMEOUT_EN
        bad_cycles = 0;
        for (int i = 1; i < 10; i++) begin
            tick();
            if (control_data !== 5'h10 || timeout !== 1'b0) bad_cycles++;
        end
        chk("tmo_move_held", 32'(bad_cycles), 32'd0);
        tick();
        chk("tmo_pulse", 32'(timeout), 32'd1);
        chk("tmo_ctrl", 32'(control_data), 32'h00);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_no_done", 32'(done), 32'd0);
        tick();
        chk("tmo_pulse_end", 32'(timeout), 32'd0);
`else
        bad_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (control_data !== 5'h10 || timeout !== 1'b0 || busy !== 1'b1) bad_cycles++;
        end
        chk("stall_move_held", 32'(bad_cycles), 32'd0);
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        chk("stall_act0", 32'(control_data), 32'h01);
        tick();
        tick();
        chk("stall_gap_done", 32'(done), 32'd1);
        tick();
        tick();
`endif
        chk("next_throw_ctrl", 32'(control_data), 32'h08);
        chk("next_throw_target", 32'(target_machine), 32'h42);
        tick();
        tick();
        chk("next_throw_done", 32'(done), 32'd1);
        tick();

        // Asynchronous reset in the middle of ACT
        drive(1'b1, 8'h51, F_THROW);
        tick();
        drive(1'b1, 8'h52, F_PUT);
        tick();
        drive(1'b0, 8'h00, F_GET);
        chk("arst_pre_ctrl", 32'(control_data), 32'h08);
        chk("arst_pre_count", 32'(fifo_count), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 32'(control_data), 32'h00);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_target", 32'(target_machine), 32'h00);
        rst_n = 1'b1;
        tick();
        chk("arst_after_busy", 32'(busy), 32'd0);
        chk("arst_after_ready", 32'(cif.cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
